// File: rtl/tx_ctrl_serdes.sv
// UART-style framed serial transmitter (start, 8 data LSB first, stop bits, optional inter-byte gap).
// Define TX_CTRL_CHKSUM_EN to append an 8-bit modulo-256 sum of the payload as a trailing byte.
module tx_ctrl_serdes #(
   parameter int MAX_LEN   = 8,
   parameter int STOP_BITS = 1,
   parameter int GAP_BITS  = 0,
   parameter int PER_W     = 20
) (
   input  logic                   clk_sys,
   input  logic                   rst,
   input  logic                   fire_tx,
   input  logic [5:0]             frame_len,
   input  logic [MAX_LEN*8-1:0]   frame_data,
   input  logic [PER_W-1:0]       tbit_period,
   output logic                   tx_ctrl,
   output logic                   busy,
   output logic                   done_tx,
   output logic                   err_tx
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_GAP,
      S_DONE
   } state_e;

   localparam logic [PER_W-1:0] ONE_P     = PER_W'(1);
   localparam logic [5:0]       MAX_LEN_L = 6'(MAX_LEN);
   localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic [3:0]       GAP_LAST  = 4'(GAP_BITS - 1);

   state_e                      state_q, state_d;
   logic [PER_W-1:0]            tmr_q, tmr_d;
   logic [PER_W-1:0]            per_q, per_d;
   logic [3:0]                  cnt_q, cnt_d;
   logic [5:0]                  idx_q, idx_d;
   logic [5:0]                  len_q, len_d;
   logic [MAX_LEN-1:0][7:0]     data_q, data_d;
   logic [7:0]                  sh_q, sh_d;
   logic                        tx_q, tx_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic                        err_q, err_d;
`ifdef TX_CTRL_CHKSUM_EN
   logic [7:0]                  sum_q, sum_d;
`endif

   logic                        tick;
   logic                        load_next;
   logic                        last_byte;
   logic [5:0]                  nxt_idx;
   logic [5:0]                  n_bytes;
   logic [7:0]                  pay_byte;
   logic [7:0]                  nxt_byte;
   logic [PER_W-1:0]            per_in;

   assign tick    = (tmr_q == '0);
   assign nxt_idx = idx_q + 6'd1;
   assign per_in  = (tbit_period == '0) ? ONE_P : tbit_period;

   always_comb begin
      pay_byte = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (nxt_idx == 6'(i)) pay_byte = data_q[i];
      end
   end

`ifdef TX_CTRL_CHKSUM_EN
   // The trailer slot sits one past the payload and carries the running sum.
   assign n_bytes  = len_q + 6'd1;
   assign nxt_byte = (nxt_idx == len_q) ? sum_q : pay_byte;
`else
   assign n_bytes  = len_q;
   assign nxt_byte = pay_byte;
`endif

   assign last_byte = (nxt_idx == n_bytes);

   always_comb begin
      // NOTE: every next-state value gets a default first so no path infers a latch.
      state_d   = state_q;
      tmr_d     = tmr_q;
      per_d     = per_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      len_d     = len_q;
      data_d    = data_q;
      sh_d      = sh_q;
      err_d     = 1'b0;
      load_next = 1'b0;
`ifdef TX_CTRL_CHKSUM_EN
      sum_d     = sum_q;
`endif

      // One shared bit-timer reloads on every bit boundary in all line-active states.
      if (state_q inside {S_START, S_DATA, S_STOP, S_GAP}) begin
         tmr_d = tick ? (per_q - ONE_P) : (tmr_q - ONE_P);
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (fire_tx) begin
               if (frame_len == '0 || frame_len > MAX_LEN_L) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_START;
                  len_d   = frame_len;
                  data_d  = frame_data;
                  per_d   = per_in;
                  tmr_d   = per_in - ONE_P;
                  cnt_d   = '0;
                  idx_d   = '0;
                  sh_d    = frame_data[7:0];
`ifdef TX_CTRL_CHKSUM_EN
                  sum_d   = frame_data[7:0];
`endif
               end
            end
         end
         S_START: begin
            if (tick) begin
               state_d = S_DATA;
               cnt_d   = '0;
            end
         end
         S_DATA: begin
            if (tick) begin
               if (cnt_q == 4'd7) begin
                  state_d = S_STOP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
                  sh_d  = {1'b0, sh_q[7:1]};
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               if (cnt_q == STOP_LAST) begin
                  cnt_d = '0;
                  if (last_byte)         state_d   = S_DONE;
                  else if (GAP_BITS > 0) state_d   = S_GAP;
                  else                   load_next = 1'b1;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         S_GAP: begin
            if (tick) begin
               if (cnt_q == GAP_LAST) begin
                  cnt_d     = '0;
                  load_next = 1'b1;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load_next) begin
         state_d = S_START;
         idx_d   = nxt_idx;
         sh_d    = nxt_byte;
`ifdef TX_CTRL_CHKSUM_EN
         if (nxt_idx < len_q) sum_d = sum_q + nxt_byte;
`endif
      end

      // Outputs are registered, so they are decoded from the state being entered.
      busy_d = (state_d inside {S_START, S_DATA, S_STOP, S_GAP});
      done_d = (state_d == S_DONE);
      if (state_d == S_START)     tx_d = 1'b0;
      else if (state_d == S_DATA) tx_d = sh_d[0];
      else                        tx_d = 1'b1;
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         per_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         data_q  <= '0;
         sh_q    <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef TX_CTRL_CHKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         per_q   <= per_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         data_q  <= data_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef TX_CTRL_CHKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   assign tx_ctrl = tx_q;
   assign busy    = busy_q;
   assign done_tx = done_q;
   assign err_tx  = err_q;

endmodule

// File: tb/tb_tx_ctrl_serdes.sv
// Directed bench for tx_ctrl_serdes: cycle-exact line/busy/done traces against a bit-level frame model.
// Instance 0 uses default parameters; instance 1 uses STOP_BITS=2, GAP_BITS=3.
module tb_tx_ctrl_serdes;
   localparam int MAX_LEN = 8;
   localparam int PER_W   = 20;
   localparam int DW      = MAX_LEN * 8;
   localparam int NTR     = 4096;
`ifdef TX_CTRL_CHKSUM_EN
   localparam int CHK = 1;
`else
   localparam int CHK = 0;
`endif

   typedef logic [7:0] byte_q_t[$];

   logic             clk_sys = 1'b0;
   logic             rst     = 1'b1;
   logic             fire_tx = 1'b0;
   logic [5:0]       frame_len   = '0;
   logic [DW-1:0]    frame_data  = '0;
   logic [PER_W-1:0] tbit_period = '0;
   logic             tx0, busy0, done0, err0;
   logic             tx1, busy1, done1, err1;

   int vectors     = 0;
   int miscompares = 0;

   logic             exp_tx[$], exp_busy[$], exp_done[$];
   logic             tr_tx  [0:1][0:NTR-1];
   logic             tr_busy[0:1][0:NTR-1];
   logic             tr_done[0:1][0:NTR-1];
   logic             tr_err [0:1][0:NTR-1];
   logic [5:0]       nxt_len;
   logic [DW-1:0]    nxt_data;
   logic [PER_W-1:0] nxt_per;

   always #5 clk_sys = ~clk_sys;

   tx_ctrl_serdes #(.MAX_LEN(MAX_LEN), .STOP_BITS(1), .GAP_BITS(0), .PER_W(PER_W)) u_dut (
      .clk_sys(clk_sys), .rst(rst), .fire_tx(fire_tx), .frame_len(frame_len),
      .frame_data(frame_data), .tbit_period(tbit_period),
      .tx_ctrl(tx0), .busy(busy0), .done_tx(done0), .err_tx(err0)
   );

   tx_ctrl_serdes #(.MAX_LEN(MAX_LEN), .STOP_BITS(2), .GAP_BITS(3), .PER_W(PER_W)) u_dut_gap (
      .clk_sys(clk_sys), .rst(rst), .fire_tx(fire_tx), .frame_len(frame_len),
      .frame_data(frame_data), .tbit_period(tbit_period),
      .tx_ctrl(tx1), .busy(busy1), .done_tx(done1), .err_tx(err1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic byte_q_t bytes_of(input logic [DW-1:0] data, input int len);
      byte_q_t q;
      for (int k = 0; k < len; k++) q.push_back(data[8*k +: 8]);
      return q;
   endfunction

   // Bytes as they appear on the line: payload, plus the modulo-256 sum when the trailer is built in.
   function automatic byte_q_t line_bytes(input byte_q_t pl);
      byte_q_t    q;
      logic [7:0] s;
      q = pl;
      s = '0;
      for (int k = 0; k < pl.size(); k++) s = s + pl[k];
      if (CHK == 1) q.push_back(s);
      return q;
   endfunction

   task automatic clear_exp();
      exp_tx.delete();
      exp_busy.delete();
      exp_done.delete();
   endtask

   task automatic push(input logic tx, input logic bsy, input logic dn, input int n);
      for (int i = 0; i < n; i++) begin
         exp_tx.push_back(tx);
         exp_busy.push_back(bsy);
         exp_done.push_back(dn);
      end
   endtask

   task automatic add_frame(input byte_q_t b, input int p, input int s, input int g);
      for (int k = 0; k < b.size(); k++) begin
         push(1'b0, 1'b1, 1'b0, p);
         for (int i = 0; i < 8; i++) push(b[k][i], 1'b1, 1'b0, p);
         push(1'b1, 1'b1, 1'b0, s * p);
         if (k != b.size() - 1) push(1'b1, 1'b1, 1'b0, g * p);
      end
      push(1'b1, 1'b0, 1'b1, 1);
   endtask

   // Presents a request for one cycle (cycle N), then scrambles the inputs; returns inside cycle N+1.
   task automatic fire(input logic [5:0] len, input logic [DW-1:0] data, input int per);
      @(posedge clk_sys); #1;
      fire_tx     = 1'b1;
      frame_len   = len;
      frame_data  = data;
      tbit_period = PER_W'(per);
      @(posedge clk_sys); #1;
      fire_tx     = 1'b0;
      frame_len   = 6'd3;
      frame_data  = ~data;
      tbit_period = PER_W'(7);
   endtask

   // Trace index k holds cycle N+1+k. A poke raises fire_tx so it is seen at the edge ending cycle N+1+poke.
   task automatic capture(input int n, input int poke);
      for (int k = 0; k < n; k++) begin
         @(negedge clk_sys);
         tr_tx[0][k] = tx0;  tr_busy[0][k] = busy0;  tr_done[0][k] = done0;  tr_err[0][k] = err0;
         tr_tx[1][k] = tx1;  tr_busy[1][k] = busy1;  tr_done[1][k] = done1;  tr_err[1][k] = err1;
         if (k == poke) begin
            fire_tx     = 1'b1;
            frame_len   = nxt_len;
            frame_data  = nxt_data;
            tbit_period = nxt_per;
         end else if (k == poke + 1) begin
            fire_tx     = 1'b0;
            frame_data  = '1;
            tbit_period = PER_W'(7);
         end
      end
      fire_tx = 1'b0;
   endtask

   task automatic compare(input string tag, input int sel);
      for (int k = 0; k < exp_tx.size(); k++) begin
         check($sformatf("%s tx@%0d", tag, k),   32'(tr_tx[sel][k]),   32'(exp_tx[k]));
         check($sformatf("%s busy@%0d", tag, k), 32'(tr_busy[sel][k]), 32'(exp_busy[k]));
         check($sformatf("%s done@%0d", tag, k), 32'(tr_done[sel][k]), 32'(exp_done[k]));
      end
   endtask

   // Mid-bit sampling of the trace, as a receiver on the pad would see it.
   task automatic decode(input string tag, input int sel, input byte_q_t b,
                         input int p, input int s, input int g);
      int         base;
      logic [7:0] v;
      base = 0;
      for (int k = 0; k < b.size(); k++) begin
         check($sformatf("%s start%0d", tag, k), 32'(tr_tx[sel][base + p/2]), 32'd0);
         for (int i = 0; i < 8; i++) v[i] = tr_tx[sel][base + (1 + i) * p + p/2];
         check($sformatf("%s byte%0d", tag, k), 32'(v), 32'(b[k]));
         base = base + p * (9 + s + g);
      end
   endtask

   function automatic int first_done(input int sel, input int n);
      for (int k = 0; k < n; k++) if (tr_done[sel][k] === 1'b1) return k;
      return -1;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int            idle_bad;
      int            d;
      byte_q_t       pl;
      byte_q_t       pl2;
      logic [DW-1:0] data;

      // Reset held for 5 cycles, then idle with no request.
      rst = 1'b1;
      repeat (5) @(posedge clk_sys);
      @(negedge clk_sys);
      check("rst tx_ctrl", 32'(tx0), 32'd1);
      check("rst busy",    32'(busy0), 32'd0);
      check("rst done_tx", 32'(done0), 32'd0);
      check("rst err_tx",  32'(err0), 32'd0);
      rst = 1'b0;
      idle_bad = 0;
      repeat (1000) begin
         @(negedge clk_sys);
         if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0) idle_bad++;
      end
      check("idle 1000 bad cycles", 32'(idle_bad), 32'd0);

      // Basic 4-byte frame at P=10; a second request mid-frame must be ignored.
      data = 64'h0000_0000_AB56_3412;
      pl   = bytes_of(data, 4);
      clear_exp();
      add_frame(line_bytes(pl), 10, 1, 0);
      push(1'b1, 1'b0, 1'b0, 6);
      nxt_len = 6'd1;  nxt_data = 64'hFF;  nxt_per = PER_W'(1);
      fire(6'd4, data, 10);
      capture(exp_tx.size(), 55);
      compare("basic", 0);
      decode("basic", 0, line_bytes(pl), 10, 1, 0);
      check("basic done index", 32'(first_done(0, exp_tx.size())), 32'(400 + 100 * CHK));

      // Checksum patterns 01 02 03 04 (sum 0A) and FF FF (sum FE).
      data = 64'h0000_0000_0403_0201;
      pl   = bytes_of(data, 4);
      clear_exp();
      add_frame(line_bytes(pl), 10, 1, 0);
      push(1'b1, 1'b0, 1'b0, 4);
      fire(6'd4, data, 10);
      capture(exp_tx.size(), -1);
      compare("sum0A", 0);
      decode("sum0A", 0, line_bytes(pl), 10, 1, 0);
      check("sum0A done index", 32'(first_done(0, exp_tx.size())), 32'(400 + 100 * CHK));

      data = 64'h0000_0000_0000_FFFF;
      pl   = bytes_of(data, 2);
      clear_exp();
      add_frame(line_bytes(pl), 10, 1, 0);
      push(1'b1, 1'b0, 1'b0, 4);
      fire(6'd2, data, 10);
      capture(exp_tx.size(), -1);
      compare("sumFE", 0);
      decode("sumFE", 0, line_bytes(pl), 10, 1, 0);

      // Rejected lengths 0 and MAX_LEN+1: one-cycle err_tx, line and busy untouched.
      for (int t = 0; t < 2; t++) begin
         string tag;
         tag = (t == 0) ? "len0" : "len9";
         clear_exp();
         push(1'b1, 1'b0, 1'b0, 6);
         fire((t == 0) ? 6'd0 : 6'd9, 64'h1122_3344_5566_7788, 10);
         capture(exp_tx.size(), -1);
         compare(tag, 0);
         check({tag, " err@0"}, 32'(tr_err[0][0]), 32'd1);
         check({tag, " err@1"}, 32'(tr_err[0][1]), 32'd0);
      end

      // tbit_period of 0 runs at one cycle per bit.
      data = 64'h5A;
      pl   = bytes_of(data, 1);
      clear_exp();
      add_frame(line_bytes(pl), 1, 1, 0);
      push(1'b1, 1'b0, 1'b0, 4);
      fire(6'd1, data, 0);
      capture(exp_tx.size(), -1);
      compare("per0", 0);
      decode("per0", 0, line_bytes(pl), 1, 1, 0);
      check("per0 done index", 32'(first_done(0, exp_tx.size())), 32'(10 + 10 * CHK));

      // Back-to-back: request in the done_tx cycle starts the next frame the following cycle.
      pl  = bytes_of(64'h81, 1);
      pl2 = bytes_of(64'h7E, 1);
      clear_exp();
      add_frame(line_bytes(pl), 2, 1, 0);
      d = exp_tx.size() - 1;
      add_frame(line_bytes(pl2), 3, 1, 0);
      push(1'b1, 1'b0, 1'b0, 4);
      nxt_len = 6'd1;  nxt_data = 64'h7E;  nxt_per = PER_W'(3);
      fire(6'd1, 64'h81, 2);
      capture(exp_tx.size(), d);
      compare("b2b", 0);

      // Reset mid-DATA (bit 2 of byte 0x00): line goes high without a clock edge, no done_tx follows.
      fire(6'd1, 64'h00, 10);
      repeat (31) @(negedge clk_sys);
      check("pre-rst tx_ctrl", 32'(tx0), 32'd0);
      #2 rst = 1'b1;
      #1;
      check("async rst tx_ctrl", 32'(tx0), 32'd1);
      check("async rst busy",    32'(busy0), 32'd0);
      @(negedge clk_sys);
      rst = 1'b0;
      clear_exp();
      push(1'b1, 1'b0, 1'b0, 120);
      capture(exp_tx.size(), -1);
      compare("post-rst", 0);

      // STOP_BITS=2, GAP_BITS=3, P=4 on the second instance (idle after the reset above).
      data = 64'h0000_0000_0000_C33C;
      pl   = bytes_of(data, 2);
      clear_exp();
      add_frame(line_bytes(pl), 4, 2, 3);
      push(1'b1, 1'b0, 1'b0, 4);
      fire(6'd2, data, 4);
      capture(exp_tx.size(), -1);
      compare("gap", 1);
      decode("gap", 1, line_bytes(pl), 4, 2, 3);
      check("gap done index", 32'(first_done(1, exp_tx.size())), 32'(100 + 56 * CHK));

      // A normal frame after the aborted one.
      data = 64'hC5;
      pl   = bytes_of(data, 1);
      clear_exp();
      add_frame(line_bytes(pl), 3, 1, 0);
      push(1'b1, 1'b0, 1'b0, 4);
      fire(6'd1, data, 3);
      capture(exp_tx.size(), -1);
      compare("after-rst", 0);
      decode("after-rst", 0, line_bytes(pl), 3, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
